rsa_two_power_arbiter: RTL and testbench
========================================

RSA_TWO_POWER_ARBITER -- requirements
Module: rsa_two_power_arbiter

Interface
REQ-001 The block SHALL have parameter MOD_WIDTH, default 256, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 2 (legal 2..4), giving the number of requester ports.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; the ports SHALL be named clk and rst.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester request accept.
REQ-008 req_power  input  NUM_REQ x MOD_WIDTH  exponent k per requester.
REQ-009 req_modulus  input  NUM_REQ x MOD_WIDTH  modulus N per requester.
REQ-010 rsp_valid  output  NUM_REQ  per-requester result valid.
REQ-011 rsp_ready  input  NUM_REQ  per-requester result accept.
REQ-012 rsp_result  output  MOD_WIDTH  shared result bus, meaningful only for the requester whose rsp_valid is high.
REQ-013 eng_i_valid / eng_i_ready  output / input  1 / 1  engine command handshake.
REQ-014 eng_i_power, eng_i_modulus  output  MOD_WIDTH each  engine operands.
REQ-015 eng_o_valid / eng_o_ready  input / output  1 / 1  engine result handshake.
REQ-016 eng_o_result  input  MOD_WIDTH  engine result, 2^k mod N.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 owner  output  2  index of the current or most recent grant.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with at most one operation outstanding.
REQ-020 In IDLE, with any req_valid high, it SHALL grant one requester by round-robin, searching from rr_ptr upward with wrap-around.
REQ-021 req_ready[i] SHALL be high only in IDLE, only for the granted i, and combinationally; at most one bit is high in any cycle.
REQ-022 On acceptance it SHALL latch power, modulus and owner into registers; later changes on req_* have no effect on the operation.
REQ-023 On acceptance with modulus >= 2 it SHALL go to ISSUE; with modulus 0 or 1 it SHALL latch result 0 and go directly to RESP without using the engine.
REQ-024 In ISSUE it SHALL drive eng_i_valid=1 with the latched operands, held stable until eng_i_ready; on handshake it SHALL go to WAIT.
REQ-025 eng_o_ready SHALL be 1 only in WAIT; on eng_o_valid it SHALL capture eng_o_result into the result register and go to RESP.
REQ-026 eng_o_valid outside WAIT SHALL be ignored and SHALL change no state.
REQ-027 In RESP it SHALL drive rsp_valid[owner]=1 and hold rsp_result stable until rsp_ready[owner]; rsp_ready on other bits SHALL be ignored.
REQ-028 On the RESP handshake it SHALL set rr_ptr to (owner+1) mod NUM_REQ and return to IDLE.
REQ-029 A new grant SHALL NOT be made in the same cycle as the RESP handshake, so there is one dead IDLE cycle minimum.
REQ-030 Latency SHALL be: acceptance to eng_i_valid 1 cycle; eng_o_valid capture to rsp_valid 1 cycle; bypass acceptance to rsp_valid 1 cycle.
REQ-031 When all requesters are valid continuously, each SHALL be served once per NUM_REQ grants, so no requester starves.
REQ-032 Operands SHALL be forwarded unmodified; k=0 SHALL return the engine result (1).

Reset
REQ-033 While rst is low: state SHALL be IDLE, rr_ptr=0, owner=0, and the result and operand registers SHALL be 0.
REQ-034 While rst is low: req_ready, rsp_valid, eng_i_valid, eng_o_ready and busy SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation with no response; the bench SHALL reset the engine together with this block.

Verification
REQ-036 Req0 only: k=5, N=13 -> eng_i_valid 1 cycle after accept; rsp_valid[0] with rsp_result=6; busy falls after the handshake.
REQ-037 Req0 and req1 raised together after reset: req0 k=8, N=251 and req1 k=10, N=1000 -> req0 first with 5, then req1 with 24; at the next simultaneous request, req1 first.
REQ-038 Req1: k=0, N=13 -> result 1; req0: N=1, k=7 -> result 0, eng_i_valid never high, rsp_valid 1 cycle after accept.
REQ-039 Backpressure: eng_i_ready low for 4 cycles, then rsp_ready low for 3 cycles -> operands and rsp_result stable throughout, and no second grant.
REQ-040 Reset pulsed while in WAIT -> all outputs 0 immediately (asynchronous); after release, a new req0 k=3, N=7 returns 1.

Source files
------------

// File: rtl/rsa_two_power_arbiter.sv
// Round-robin arbiter that shares one 2^k mod N engine among NUM_REQ requesters.
// At most one operation is in flight; moduli 0 and 1 are answered locally with 0.
module rsa_two_power_arbiter #(
   parameter int MOD_WIDTH = 256,
   parameter int NUM_REQ   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0][MOD_WIDTH-1:0] req_power,
   input  logic [NUM_REQ-1:0][MOD_WIDTH-1:0] req_modulus,
   output logic [NUM_REQ-1:0]                rsp_valid,
   input  logic [NUM_REQ-1:0]                rsp_ready,
   output logic [MOD_WIDTH-1:0]              rsp_result,
   output logic                              eng_i_valid,
   input  logic                              eng_i_ready,
   output logic [MOD_WIDTH-1:0]              eng_i_power,
   output logic [MOD_WIDTH-1:0]              eng_i_modulus,
   input  logic                              eng_o_valid,
   output logic                              eng_o_ready,
   input  logic [MOD_WIDTH-1:0]              eng_o_result,
   output logic                              busy,
   output logic [1:0]                        owner
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   localparam logic [2:0] NREQ3    = 3'(NUM_REQ);
   localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

   state_e               state_q, state_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [1:0]           owner_q, owner_d;
   logic [MOD_WIDTH-1:0] power_q, power_d;
   logic [MOD_WIDTH-1:0] modulus_q, modulus_d;
   logic [MOD_WIDTH-1:0] result_q, result_d;

   logic                 grant_vld;
   logic [1:0]           grant_idx;
   logic [2:0]           cand_sum;
   logic                 cand_vld;
   logic [MOD_WIDTH-1:0] sel_power;
   logic [MOD_WIDTH-1:0] sel_modulus;
   logic                 owner_rsp_ready;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld   = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand_vld    = 1'b0;
      sel_power   = '0;
      sel_modulus = '0;
      for (int o = 0; o < NUM_REQ; o++) begin
         cand_sum = {1'b0, rr_ptr_q} + 3'(o);
         if (cand_sum >= NREQ3) begin
            cand_sum = cand_sum - NREQ3;
         end
         cand_vld = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cand_sum[1:0] == 2'(i)) begin
               cand_vld = req_valid[i];
            end
         end
         if (!grant_vld && cand_vld) begin
            grant_vld = 1'b1;
            grant_idx = cand_sum[1:0];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == 2'(i)) begin
            sel_power   = req_power[i];
            sel_modulus = req_modulus[i];
         end
      end
   end

   always_comb begin
      owner_rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == 2'(i)) begin
            owner_rsp_ready = rsp_ready[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      power_d     = power_q;
      modulus_d   = modulus_q;
      result_d    = result_q;
      eng_i_valid = 1'b0;
      eng_o_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_vld) begin
               owner_d   = grant_idx;
               power_d   = sel_power;
               modulus_d = sel_modulus;
               if (sel_modulus > MOD_WIDTH'(1)) begin
                  state_d = S_ISSUE;
               end else begin
                  result_d = '0;
                  state_d  = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            eng_i_valid = 1'b1;
            if (eng_i_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            eng_o_ready = 1'b1;
            if (eng_o_valid) begin
               result_d = eng_o_result;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (owner_rsp_ready) begin
               rr_ptr_d = (owner_q == LAST_IDX) ? 2'd0 : owner_q + 2'd1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // req_ready is combinational, so it is also masked while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = rst && (state_q == S_IDLE) && grant_vld && (grant_idx == 2'(i));
         rsp_valid[i] = (state_q == S_RESP) && (owner_q == 2'(i));
      end
   end

   assign eng_i_power   = power_q;
   assign eng_i_modulus = modulus_q;
   assign rsp_result    = result_q;
   assign busy          = (state_q != S_IDLE);
   assign owner         = owner_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         power_q   <= '0;
         modulus_q <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         power_q   <= power_d;
         modulus_q <= modulus_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_rsa_two_power_arbiter.sv
// Directed bench for rsa_two_power_arbiter with a behavioural 2^k mod N engine
// and a queue of expected responses filled at acceptance time.
module tb_rsa_two_power_arbiter;

   localparam int MW = 256;
   localparam int NR = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NR-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NR-1:0][MW-1:0] req_power, req_modulus;
   logic [MW-1:0]         rsp_result, eng_i_power, eng_i_modulus, eng_o_result;
   logic                  eng_i_valid, eng_i_ready, eng_o_valid, eng_o_ready, busy;
   logic [1:0]            owner;

   rsa_two_power_arbiter #(.MOD_WIDTH(MW), .NUM_REQ(NR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_power(req_power), .req_modulus(req_modulus),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready),
      .eng_i_power(eng_i_power), .eng_i_modulus(eng_i_modulus),
      .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_o_result(eng_o_result),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Behavioural engine: accepts one command, answers eng_lat cycles later.
   logic          eng_rdy_en, eng_spur, eng_pend;
   int            eng_lat, eng_cnt;
   logic [MW-1:0] eng_res;

   function automatic logic [MW-1:0] pow2mod(input logic [MW-1:0] k, input logic [MW-1:0] n);
      logic [MW:0] r;
      r = (MW+1)'(1) % {1'b0, n};
      for (int i = 0; i < int'(k[15:0]); i++) r = (r << 1) % {1'b0, n};
      return r[MW-1:0];
   endfunction

   assign eng_i_ready  = eng_rdy_en && !eng_pend;
   assign eng_o_valid  = (eng_pend && eng_cnt == 0) || eng_spur;
   assign eng_o_result = eng_res;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_pend <= 1'b0;
         eng_cnt  <= 0;
         eng_res  <= '0;
      end else if (!eng_pend) begin
         if (eng_i_valid && eng_i_ready) begin
            eng_pend <= 1'b1;
            eng_cnt  <= eng_lat;
            eng_res  <= pow2mod(eng_i_power, eng_i_modulus);
         end
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
      end else if (eng_o_ready) begin
         eng_pend <= 1'b0;
      end
   end

   typedef struct {
      logic [1:0]    who;
      logic [MW-1:0] res;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] who, input logic [MW-1:0] res);
      exp_t e;
      e.who = who;
      e.res = res;
      sb_q.push_back(e);
   endtask

   task automatic set_req(input bit which, input logic [MW-1:0] k, input logic [MW-1:0] n);
      req_valid[which]   = 1'b1;
      req_power[which]   = k;
      req_modulus[which] = n;
   endtask

   // Called at a negedge; waits for a response, holds it for 'hold' cycles
   // (with only the non-owner rsp_ready bit high), then completes the handshake.
   task automatic wait_rsp(input int hold);
      int   cyc;
      exp_t e;
      logic [NR-1:0] own_bit;
      cyc = 0;
      while (rsp_valid == '0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("rsp_arrived", MW'(rsp_valid != '0), MW'(1));
      if (rsp_valid == '0) return;
      check("sb_nonempty", MW'(sb_q.size() != 0), MW'(1));
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      own_bit = NR'(1) << e.who;
      for (int h = 0; h <= hold; h++) begin
         rsp_ready = ~own_bit;
         #1;
         check("rsp_valid", MW'(rsp_valid), MW'(own_bit));
         check("rsp_result", rsp_result, e.res);
         check("rsp_owner", MW'(owner), MW'(e.who));
         check("no_grant_in_resp", MW'(req_ready), '0);
         if (h < hold) @(negedge clk);
      end
      rsp_ready = own_bit;
      @(negedge clk);
      rsp_ready = '0;
      check("idle_after_hs", MW'(busy), '0);
      check("rsp_dropped", MW'(rsp_valid), '0);
   endtask

   initial begin
      rst         = 1'b0;
      req_valid   = '0;
      rsp_ready   = '0;
      req_power   = '0;
      req_modulus = '0;
      eng_rdy_en  = 1'b1;
      eng_spur    = 1'b0;
      eng_lat     = 2;
      repeat (3) @(negedge clk);

      // Reset state
      req_valid = 2'b11;
      #1;
      check("rst_req_ready", MW'(req_ready), '0);
      check("rst_busy", MW'(busy), '0);
      check("rst_owner", MW'(owner), '0);
      check("rst_rsp_valid", MW'(rsp_valid), '0);
      check("rst_eng_i_valid", MW'(eng_i_valid), '0);
      check("rst_eng_o_ready", MW'(eng_o_ready), '0);
      check("rst_result", rsp_result, '0);
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);

      // Single request: 2^5 mod 13 = 6
      set_req(1'b0, 5, 13);
      #1;
      check("t1_ready", MW'(req_ready), MW'(2'b01));
      push(2'd0, 6);
      @(negedge clk);
      req_valid = '0;
      check("t1_issue", MW'(eng_i_valid), MW'(1));
      check("t1_power", eng_i_power, 5);
      check("t1_modulus", eng_i_modulus, 13);
      check("t1_busy", MW'(busy), MW'(1));
      wait_rsp(0);

      // Simultaneous requests after reset: req0 first, then req1 at the next tie
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      set_req(1'b0, 8, 251);
      set_req(1'b1, 10, 1000);
      #1;
      check("t2_first_grant", MW'(req_ready), MW'(2'b01));
      push(2'd0, 5);
      @(negedge clk);
      wait_rsp(0);
      check("t2_second_grant", MW'(req_ready), MW'(2'b10));
      push(2'd1, 24);
      @(negedge clk);
      wait_rsp(0);
      check("t2_third_grant", MW'(req_ready), MW'(2'b01));
      push(2'd0, 5);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(0);

      // k = 0 through the engine, then modulus 1 bypass
      set_req(1'b1, 0, 13);
      #1;
      check("t3_ready_k0", MW'(req_ready), MW'(2'b10));
      push(2'd1, 1);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(0);
      set_req(1'b0, 7, 1);
      #1;
      check("t3_ready_bypass", MW'(req_ready), MW'(2'b01));
      push(2'd0, 0);
      @(negedge clk);
      req_valid = '0;
      check("t3_bypass_no_eng", MW'(eng_i_valid), '0);
      check("t3_bypass_rsp_1cyc", MW'(rsp_valid), MW'(2'b01));
      wait_rsp(0);

      // Engine and response backpressure, changing req_* and a stray eng_o_valid
      eng_rdy_en = 1'b0;
      set_req(1'b0, 5, 13);
      #1;
      check("t4_ready", MW'(req_ready), MW'(2'b01));
      push(2'd0, 6);
      @(negedge clk);
      set_req(1'b0, 99, 77);
      set_req(1'b1, 3, 7);
      eng_spur = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("t4_eng_valid_held", MW'(eng_i_valid), MW'(1));
         check("t4_power_stable", eng_i_power, 5);
         check("t4_modulus_stable", eng_i_modulus, 13);
         check("t4_no_grant", MW'(req_ready), '0);
         @(negedge clk);
      end
      eng_spur   = 1'b0;
      eng_rdy_en = 1'b1;
      check("t4_still_issue", MW'(eng_i_valid), MW'(1));
      wait_rsp(3);
      check("t4_next_grant", MW'(req_ready), MW'(2'b10));
      push(2'd1, 1);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(0);

      // Reset while waiting on the engine
      eng_lat = 10;
      set_req(1'b0, 4, 11);
      #1;
      check("t5_ready", MW'(req_ready), MW'(2'b01));
      push(2'd0, 5);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("t5_in_wait", MW'(eng_o_ready), MW'(1));
      #2;
      rst = 1'b0;
      #1;
      check("t5_busy", MW'(busy), '0);
      check("t5_eng_o_ready", MW'(eng_o_ready), '0);
      check("t5_eng_i_valid", MW'(eng_i_valid), '0);
      check("t5_rsp_valid", MW'(rsp_valid), '0);
      check("t5_owner", MW'(owner), '0);
      check("t5_result", rsp_result, '0);
      check("t5_operand", eng_i_power, '0);
      sb_q.delete();
      req_valid = 2'b01;
      #1;
      check("t5_req_ready", MW'(req_ready), '0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      eng_lat = 2;
      @(negedge clk);
      set_req(1'b0, 3, 7);
      #1;
      check("t5_ready_after", MW'(req_ready), MW'(2'b01));
      push(2'd0, 1);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(0);

      check("sb_drained", MW'(sb_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
